// File: rtl/ram_arbiter_pkg.sv
// Shared defaults and types for the two-port RAM arbiter.
package ram_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 2;
    localparam int CNT_WIDTH_DEF  = 16;

    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant logic with its priority pointer.
module rr_arbiter2
    import ram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic valid0,
    input  logic valid1,
    output logic grant0,
    output logic grant1
);

    req_idx_t prio;

    // Grants are forced low while reset is held so ready stays quiet.
    assign grant0 = rst_n & valid0 & (~valid1 | (prio == REQ0));
    assign grant1 = rst_n & valid1 & (~valid0 | (prio == REQ1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio <= REQ0;
        end else if (grant0) begin
            prio <= REQ1;
        end else if (grant1) begin
            prio <= REQ0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two requesters sharing one external single-port RAM, round-robin arbitrated.
module ram_port_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_data,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [CNT_WIDTH-1:0]  grant_cnt0,
    output logic [CNT_WIDTH-1:0]  grant_cnt1
);

    logic     grant0;
    logic     grant1;
    logic     accept;
    logic     rsp_pend;
    req_idx_t rsp_owner;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign accept     = grant0 | grant1;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant0) begin
            mem_en    = 1'b1;
            mem_we    = req0_we;
            mem_addr  = req0_addr;
            mem_wdata = req0_wdata;
        end else if (grant1) begin
            mem_en    = 1'b1;
            mem_we    = req1_we;
            mem_addr  = req1_addr;
            mem_wdata = req1_wdata;
        end
    end

    // Owner tag remembers who issued the read whose data returns next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend  <= 1'b0;
            rsp_owner <= REQ0;
        end else begin
            rsp_pend <= accept & ~mem_we;
            if (accept) begin
                rsp_owner <= grant1 ? REQ1 : REQ0;
            end
        end
    end

    assign rsp0_valid = rsp_pend & (rsp_owner == REQ0);
    assign rsp1_valid = rsp_pend & (rsp_owner == REQ1);
    assign rsp0_data  = rsp0_valid ? mem_rdata : '0;
    assign rsp1_data  = rsp1_valid ? mem_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (grant0) grant_cnt0 <= grant_cnt0 + 1'b1;
            if (grant1) grant_cnt1 <= grant_cnt1 + 1'b1;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter with a behavioural model.
module tb_ram_port_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req0_we = 1'b0;
    logic [1:0] req0_addr = '0;
    logic [7:0] req0_wdata = '0;
    logic       req1_valid = 1'b0, req1_we = 1'b0;
    logic [1:0] req1_addr = '0;
    logic [7:0] req1_wdata = '0;
    logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [7:0] rsp0_data, rsp1_data;
    logic       mem_en, mem_we;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [15:0] grant_cnt0, grant_cnt1;

    int passed = 0;
    int total  = 0;

    ram_port_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    always #5 clk = ~clk;

    // External RAM, one-cycle read latency.
    logic [7:0] ram [4];
    initial for (int i = 0; i < 4; i++) ram[i] = 8'(i * 17 + 3);
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else
            passed++;
    endtask

    // Behavioural model: last granted, pending read, shadow memory, counts.
    int         last_g = 1;
    bit         pend_v = 0;
    int         pend_o = 0;
    logic [7:0] pend_d = '0;
    logic [7:0] shadow [4];
    int         c0 = 0, c1 = 0;
    initial for (int i = 0; i < 4; i++) shadow[i] = 8'(i * 17 + 3);

    always @(negedge clk) begin
        int g;
        logic ew;
        logic [1:0] ea;
        logic [7:0] ed;
        if (!rst_n) begin
            chk("rst_ready0", {31'b0, req0_ready}, 0);
            chk("rst_ready1", {31'b0, req1_ready}, 0);
            chk("rst_rsp", {30'b0, rsp0_valid, rsp1_valid}, 0);
            chk("rst_rdata", {16'b0, rsp0_data, rsp1_data}, 0);
            chk("rst_mem", {30'b0, mem_en, mem_we}, 0);
            chk("rst_cnt", {grant_cnt0, grant_cnt1}, 0);
            last_g = 1; pend_v = 0; c0 = 0; c1 = 0;
        end else begin
            g = -1;
            if (req0_valid && req1_valid) g = 1 - last_g;
            else if (req0_valid) g = 0;
            else if (req1_valid) g = 1;
            ew = (g == 0) ? req0_we : (g == 1) ? req1_we : 1'b0;
            ea = (g == 1) ? req1_addr : req0_addr;
            ed = (g == 1) ? req1_wdata : req0_wdata;
            chk("ready0", {31'b0, req0_ready}, (g == 0) ? 1 : 0);
            chk("ready1", {31'b0, req1_ready}, (g == 1) ? 1 : 0);
            chk("mem_en", {31'b0, mem_en}, (g >= 0) ? 1 : 0);
            chk("mem_we", {31'b0, mem_we}, {31'b0, ew});
            if (g >= 0) begin
                chk("mem_addr", {30'b0, mem_addr}, {30'b0, ea});
                chk("mem_wdata", {24'b0, mem_wdata}, {24'b0, ed});
            end
            chk("rsp0_valid", {31'b0, rsp0_valid}, (pend_v && pend_o == 0) ? 1 : 0);
            chk("rsp1_valid", {31'b0, rsp1_valid}, (pend_v && pend_o == 1) ? 1 : 0);
            if (pend_v && pend_o == 0) chk("rsp0_data", {24'b0, rsp0_data}, {24'b0, pend_d});
            if (pend_v && pend_o == 1) chk("rsp1_data", {24'b0, rsp1_data}, {24'b0, pend_d});
            chk("grant_cnt0", {16'b0, grant_cnt0}, c0);
            chk("grant_cnt1", {16'b0, grant_cnt1}, c1);
            pend_v = 0;
            if (g >= 0) begin
                last_g = g;
                if (g == 0) c0 = (c0 + 1) & 32'hFFFF;
                else        c1 = (c1 + 1) & 32'hFFFF;
                if (ew) shadow[ea] = ed;
                else begin pend_v = 1; pend_o = g; pend_d = shadow[ea]; end
            end
        end
    end

    task automatic drive(input logic v0, input logic w0, input logic [1:0] a0,
                         input logic [7:0] d0, input logic v1, input logic w1,
                         input logic [1:0] a1, input logic [7:0] d1);
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
    endtask

    initial begin
        step();
        do_reset();

        // write 0x5A to addr 1, read it back
        drive(1, 1, 2'd1, 8'h5A, 0, 0, 0, 0); step();
        drive(1, 0, 2'd1, 8'h00, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s1_rsp0_valid", {31'b0, rsp0_valid}, 1);
        chk("s1_rsp0_data", {24'b0, rsp0_data}, 32'h5A);
        chk("s1_cnt0", {16'b0, grant_cnt0}, 2);
        step();

        // both valid for 6 cycles alternate starting with req0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 2'(i), 8'(i), 1, 1, 2'(i + 1), 8'(i + 8));
            @(negedge clk);
            chk("s2_alt0", {31'b0, req0_ready}, ((i % 2) == 0) ? 1 : 0);
            chk("s2_alt1", {31'b0, req1_ready}, ((i % 2) == 1) ? 1 : 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s2_cnt0", {16'b0, grant_cnt0}, 3);
        chk("s2_cnt1", {16'b0, grant_cnt1}, 3);
        step();

        // req1 writes 0x33 @3, req0 reads @3 next cycle
        drive(0, 0, 0, 0, 1, 1, 2'd3, 8'h33); step();
        drive(1, 0, 2'd3, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s3_rsp0_data", {24'b0, rsp0_data}, 32'h33);
        chk("s3_rsp1_valid", {31'b0, rsp1_valid}, 0);
        step();
        @(negedge clk);
        chk("s3_rsp1_after", {31'b0, rsp1_valid}, 0);
        step();

        // reset right after a read acceptance drops the response
        drive(1, 0, 2'd2, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1, 0, 2'd0, 0, 1, 0, 2'd1, 0);
        @(negedge clk);
        chk("s4_rsp", {30'b0, rsp0_valid, rsp1_valid}, 0);
        chk("s4_cnt", {grant_cnt0, grant_cnt1}, 0);
        chk("s4_first", {30'b0, req0_ready, req1_ready}, 32'h2);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();

        // grant_cnt1 wraps after 65536 acceptances
        do_reset();
        drive(0, 0, 0, 0, 1, 1, 2'd0, 8'hC3);
        repeat (65535) step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s5_cnt1_max", {16'b0, grant_cnt1}, 32'hFFFF);
        step();
        drive(0, 0, 0, 0, 1, 1, 2'd0, 8'h11); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("s5_cnt1_wrap", {16'b0, grant_cnt1}, 0);
        step();

        // randomized traffic with occasional reset
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
                      8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom),
                      2'($urandom), 8'($urandom));
                step();
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step(); step();
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, as the width of the data word.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 2, as the shared RAM address width (4 entries).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, as the width of each grant statistics counter.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-006 The block SHALL have ports reqN_valid, input, 1 bit (N in {0,1}), requester N has a pending access.
REQ-007 The block SHALL have ports reqN_ready, output, 1 bit, access of requester N is accepted this cycle.
REQ-008 The block SHALL have ports reqN_we, input, 1 bit, 1 = write, 0 = read.
REQ-009 The block SHALL have ports reqN_addr, input, ADDR_WIDTH bits, the access address.
REQ-010 The block SHALL have ports reqN_wdata, input, DATA_WIDTH bits, the write data.
REQ-011 The block SHALL have ports rspN_valid, output, 1 bit, a one-cycle read-response strobe.
REQ-012 The block SHALL have ports rspN_data, output, DATA_WIDTH bits, the read data, meaningful only while rspN_valid is high.
REQ-013 The block SHALL have port mem_en, output, 1 bit, RAM access strobe.
REQ-014 The block SHALL have port mem_we, output, 1 bit, RAM write enable.
REQ-015 The block SHALL have port mem_addr, output, ADDR_WIDTH bits, RAM address.
REQ-016 The block SHALL have port mem_wdata, output, DATA_WIDTH bits, RAM write data.
REQ-017 The block SHALL have port mem_rdata, input, DATA_WIDTH bits, RAM read data, valid one cycle after a read strobe.
REQ-018 The block SHALL have ports grant_cnt0 and grant_cnt1, output, CNT_WIDTH bits, the accepted-access count per requester.

Function
REQ-019 The block SHALL accept at most one access per cycle; acceptance means reqN_valid && reqN_ready.
REQ-020 reqN_ready SHALL be combinational from the valid inputs and the priority pointer, and high only for the granted requester.
REQ-021 With a single valid requester, that requester SHALL be granted in the same cycle.
REQ-022 With both requesters valid, the block SHALL grant the requester not granted last (round-robin).
REQ-023 The priority pointer SHALL favour req0 after reset.
REQ-024 The priority pointer SHALL update only on acceptance.
REQ-025 On acceptance, mem_en = 1 and mem_we/mem_addr/mem_wdata SHALL equal the granted requester's fields in the same cycle.
REQ-026 When no access is accepted, mem_en and mem_we SHALL be 0.
REQ-027 An accepted read SHALL produce rspN_valid = 1 for exactly one cycle, one cycle after acceptance, with rspN_data = mem_rdata.
REQ-028 Response routing SHALL use a registered owner tag; there is no response back-pressure.
REQ-029 Accepted writes SHALL produce no response.
REQ-030 Accesses SHALL reach the RAM in acceptance order; a read accepted the cycle after a write to the same address returns the new data.
REQ-031 A requester holding reqN_valid high SHALL be granted within 2 cycles (no starvation).
REQ-032 A requester SHALL NOT be granted twice in a row while the other is valid.
REQ-033 grant_cntN SHALL increment by 1 on each acceptance of requester N.
REQ-034 grant_cntN SHALL wrap from 2^CNT_WIDTH-1 to 0 without a flag.

Reset
REQ-035 While rst_n = 0, all outputs SHALL be 0: ready, rsp, mem and counter outputs.
REQ-036 While rst_n = 0, the pointer SHALL favour req0 and the owner tag SHALL be cleared.
REQ-037 Assertion of rst_n mid-operation SHALL discard any pending read response; no rspN_valid appears after release.
REQ-038 The first acceptance SHALL be possible in the first rising edge after rst_n deasserts.

Structure
REQ-039 A shared package ram_arbiter_pkg SHALL hold the DATA_WIDTH, ADDR_WIDTH and CNT_WIDTH defaults and the requester-index type.
REQ-040 The block SHALL have one sub-module, rr_arbiter2: two-input round-robin grant logic with the pointer register.
REQ-041 The RAM SHALL be external to this block.

Verification
REQ-042 Scenario: after reset, req0 writes 0x5A to addr 1, then req0 reads addr 1 -> rsp0_valid one cycle after the read acceptance, rsp0_data = 0x5A, grant_cnt0 = 2.
REQ-043 Scenario: both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1 and grant_cnt0 = grant_cnt1 = 3.
REQ-044 Scenario: req1 writes 0x33 to addr 3 and req0 reads addr 3 the next cycle -> rsp0_data = 0x33 and rsp1_valid never asserts.
REQ-045 Scenario: rst_n pulsed low the cycle after a read acceptance -> no rspN_valid, all counters 0, and the next grant with both valid goes to req0.
REQ-046 Scenario: grant_cnt1 preloaded by 65535 accesses, then one more -> grant_cnt1 = 0.
